// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the CPU instruction RAM.
// The loader's optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

    localparam int IMEM_DEPTH_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_word_asm.sv
// Packs accepted bytes MSB-first into 32-bit words and pulses o_word_vld
// one cycle after the fourth byte of each word is accepted.
module imem_word_asm (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_word_vld,
    output logic [31:0] o_word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        vld_q, vld_d;

    assign o_last_byte = i_accept && (cnt_q == 2'd3);
    assign o_word_vld  = vld_q;
    assign o_word      = word_q;

    // The finished word is copied out so the shifter can take the next byte
    // during the write cycle while the RAM data stays stable.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        vld_d   = 1'b0;
        if (i_clr) begin
            cnt_d   = 2'd0;
            shift_d = 32'd0;
        end else if (i_accept) begin
            shift_d = {shift_q[23:0], i_byte};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                vld_d  = 1'b1;
                word_d = {shift_q[23:0], i_byte};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
            word_q  <= 32'd0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: header byte N, then N big-endian words,
// then (with IMEM_LOADER_CHECKSUM_EN defined) one XOR checksum byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEF,
    parameter int ADR_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_vld,
    output logic             o_byte_rdy,
    output logic             o_wr_en,
    output logic [ADR_W-1:0] o_wr_adr,
    output logic [31:0]      o_wr_dat,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_cpu_rst_n
);

    state_t           state_q, state_d;
    logic [7:0]       n_q, n_d;
    logic [7:0]       idx_q, idx_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             accept;
    logic             asm_accept;
    logic             asm_clr;
    logic             last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    assign o_byte_rdy  = (state_q == ST_HDR) || (state_q == ST_DATA)
                      || (state_q == ST_CSUM);
    assign o_busy      = o_byte_rdy;
    assign o_done      = (state_q == ST_DONE);
    assign o_err       = (state_q == ST_ERR);
    assign o_cpu_rst_n = o_done;
    assign o_wr_adr    = adr_q;

    assign accept     = i_byte_vld && o_byte_rdy;
    assign asm_accept = accept && (state_q == ST_DATA);
    assign asm_clr    = accept && (state_q == ST_HDR);

    imem_word_asm u_asm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (asm_clr),
        .i_accept    (asm_accept),
        .i_byte      (i_byte),
        .o_last_byte (last_byte),
        .o_word_vld  (o_wr_en),
        .o_word      (o_wr_dat)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        adr_d   = adr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (asm_accept) begin
            csum_d = csum_q ^ i_byte;
        end
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    state_d = ST_HDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if ((i_byte == 8'd0) || (32'(i_byte) > DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = i_byte;
                        idx_d   = 8'd0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_byte) begin
                    // Address is latched with the word so both appear together on o_wr_en.
                    adr_d = ADR_W'({idx_q, 2'b00});
                    if (idx_q == (n_q - 8'd1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (i_byte == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= 8'd0;
            idx_q   <= 8'd0;
            adr_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: drives byte images with random stalls and
// compares every write and final status against an image-level reference.
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_byte;
    logic        i_byte_vld;
    logic        o_byte_rdy;
    logic        o_wr_en;
    logic [31:0] o_wr_adr;
    logic [31:0] o_wr_dat;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_cpu_rst_n;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    int rdy_drop = 0;
    logic [31:0] img [0:255];

    always #5 i_clk = ~i_clk;

    imem_loader #(.DEPTH(64), .ADR_W(32)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_byte      (i_byte),
        .i_byte_vld  (i_byte_vld),
        .o_byte_rdy  (o_byte_rdy),
        .o_wr_en     (o_wr_en),
        .o_wr_adr    (o_wr_adr),
        .o_wr_dat    (o_wr_dat),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_cpu_rst_n (o_cpu_rst_n)
    );

    always @(negedge i_clk) begin
        if (o_wr_en === 1'b1) wr_count++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
        int   tries;
        logic ok;
        i_byte_vld = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (o_byte_rdy !== 1'b1) rdy_drop++;
            @(negedge i_clk);
        end
        i_byte     = b;
        i_byte_vld = 1'b1;
        i_start    = with_start;
        ok    = 1'b0;
        tries = 0;
        while (!ok && tries < 50) begin
            ok = o_byte_rdy;
            @(posedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
            tries++;
        end
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_load(input int n, input int gmin, input int gmax,
                            input bit csum_good, input int abort_after, input string tag);
        int         base;
        logic [7:0] x;
        logic [7:0] b;
        bit         exp_done;
        x = 8'd0;
        rdy_drop = 0;
        i_byte_vld = 1'b0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check({tag, "_busy_hdr"}, 64'(o_busy), 64'd1);
        base = wr_count;
        send_byte(8'(n), $urandom_range(gmax, gmin), 1'b0);
        if (n < 1 || n > 64) begin
            i_byte_vld = 1'b0;
            check({tag, "_flags"}, 64'({o_byte_rdy, o_busy, o_done, o_err, o_cpu_rst_n}), 64'b00010);
            repeat (3) @(negedge i_clk);
            check({tag, "_no_writes"}, 64'(wr_count - base), 64'd0);
            $display("load %s N=%0d writes=%0d err=%0b", tag, n, wr_count - base, o_err);
            return;
        end
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = img[w][31 - 8*k -: 8];
                x ^= b;
                send_byte(b, $urandom_range(gmax, gmin), (w == 0 && k == 1));
                if (k == 3) begin
                    check({tag, "_wr_en"}, 64'(o_wr_en), 64'd1);
                    check({tag, "_wr_adr"}, 64'(o_wr_adr), 64'(w * 4));
                    check({tag, "_wr_dat"}, 64'(o_wr_dat), 64'(img[w]));
                    if (abort_after == w + 1) begin
                        i_rst_n = 1'b0;
                        #1;
                        check({tag, "_rst_flags"},
                              64'({o_byte_rdy, o_wr_en, o_busy, o_done, o_err, o_cpu_rst_n}), 64'd0);
                        check({tag, "_rst_adr"}, 64'(o_wr_adr), 64'd0);
                        check({tag, "_rst_dat"}, 64'(o_wr_dat), 64'd0);
                        i_byte_vld = 1'b0;
                        repeat (3) @(negedge i_clk);
                        check({tag, "_abort_writes"}, 64'(wr_count - base), 64'(w + 1));
                        i_rst_n = 1'b1;
                        $display("load %s N=%0d aborted after %0d writes", tag, n, wr_count - base);
                        return;
                    end
                end else begin
                    check({tag, "_wr_idle"}, 64'(o_wr_en), 64'd0);
                    if (w > 0) begin
                        check({tag, "_adr_hold"}, 64'(o_wr_adr), 64'((w - 1) * 4));
                        check({tag, "_dat_hold"}, 64'(o_wr_dat), 64'(img[w - 1]));
                    end
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({tag, "_csum_wait"}, 64'({o_busy, o_done}), 64'b10);
        send_byte(csum_good ? x : (x ^ 8'h01), $urandom_range(gmax, gmin), 1'b0);
        exp_done = csum_good;
`else
        exp_done = 1'b1;
`endif
        i_byte_vld = 1'b0;
        check({tag, "_final"}, 64'({o_byte_rdy, o_busy, o_done, o_err, o_cpu_rst_n}),
              64'({1'b0, 1'b0, exp_done, ~exp_done, exp_done}));
        repeat (2) @(negedge i_clk);
        check({tag, "_write_count"}, 64'(wr_count - base), 64'(n));
        check({tag, "_rdy_stall"}, 64'(rdy_drop), 64'd0);
        check({tag, "_wr_quiet"}, 64'(o_wr_en), 64'd0);
        $display("load %s N=%0d writes=%0d done=%0b err=%0b", tag, n, wr_count - base, o_done, o_err);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_byte     = 8'd0;
        i_byte_vld = 1'b0;
        repeat (2) @(negedge i_clk);
        check("reset_flags", 64'({o_byte_rdy, o_wr_en, o_busy, o_done, o_err, o_cpu_rst_n}), 64'd0);
        check("reset_adr", 64'(o_wr_adr), 64'd0);
        check("reset_dat", 64'(o_wr_dat), 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        $display("reset released");

        img[0] = 32'h2008_0005;
        img[1] = 32'h8C09_0004;
        run_load(2, 0, 0, 1'b1, -1, "normal");

        run_load(0, 0, 0, 1'b1, -1, "hdr_zero");
        run_load(65, 0, 0, 1'b1, -1, "hdr_65");
        run_load($urandom_range(255, 66), 0, 2, 1'b1, -1, "hdr_rand");

        img[0] = 32'h1234_5678;
        run_load(1, 5, 5, 1'b1, -1, "stall");

        for (int i = 0; i < 64; i++) img[i] = 32'h0100_0000 + i;
        run_load(64, 0, 0, 1'b1, -1, "full");
        run_load(64, 0, 1, 1'b1, 10, "abort");
        img[0] = 32'hDEAD_BEEF;
        run_load(1, 0, 1, 1'b1, -1, "after_abort");

        img[0] = 32'hA5A5_A5A5;
        run_load(1, 0, 0, 1'b1, -1, "csum_good");
        run_load(1, 0, 0, 1'b0, -1, "csum_bad");

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(64, 1);
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_load(n, 0, 2, 1'($urandom_range(1, 0)), -1, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
